// File: rtl/cell_pos_reader.sv
// Streaming read controller for one per-cell position RAM: count fetch, then credit-limited particle reads into a small FIFO.
// Optional stall counter output enabled by defining CELL_READER_STALL_CNT_EN.
module cell_pos_reader #(
    parameter int DATA_WIDTH   = 96,
    parameter int ADDR_WIDTH   = 8,
    parameter int PARTICLE_NUM = 220,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_rden,
    output logic                  ram_wren,
    input  logic [DATA_WIDTH-1:0] ram_q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_pos,
    output logic [ADDR_WIDTH-1:0] out_pid,
    output logic                  out_last,
    output logic [ADDR_WIDTH-1:0] particle_count,
    output logic                  count_err
`ifdef CELL_READER_STALL_CNT_EN
   ,output logic [15:0]           stall_cycles
`endif
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] CNT_RD   = 3'd1;
    localparam logic [2:0] CNT_WAIT = 3'd2;
    localparam logic [2:0] STREAM   = 3'd3;
    localparam logic [2:0] DRAIN    = 3'd4;

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CW    = PTR_W + 2;
    localparam logic [ADDR_WIDTH-1:0] MAX_COUNT = ADDR_WIDTH'(PARTICLE_NUM - 1);

    logic [2:0]            state;
    logic                  wait_phase;
    logic [ADDR_WIDTH-1:0] issue_ptr;
    logic [ADDR_WIDTH-1:0] addr_hold;
    logic [ADDR_WIDTH-1:0] raw_count;

    logic                  pipe_v1, pipe_v2;
    logic [ADDR_WIDTH-1:0] pipe_pid1, pipe_pid2;

    logic [DATA_WIDTH-1:0] fifo_pos  [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] fifo_pid  [FIFO_DEPTH];
    logic                  fifo_last [FIFO_DEPTH];
    logic [PTR_W:0]        wr_ptr, rd_ptr, occupancy;
    logic [CW-1:0]         credit_used;

    logic issue, fire;

    // A read may only be issued if its data is guaranteed a FIFO slot on return.
    assign occupancy   = wr_ptr - rd_ptr;
    assign credit_used = CW'(occupancy) + CW'(pipe_v1) + CW'(pipe_v2);
    assign issue       = (state == STREAM) && (credit_used < CW'(FIFO_DEPTH));
    assign fire        = out_valid && out_ready;
    assign raw_count   = ram_q[ADDR_WIDTH-1:0];

    assign busy      = (state != IDLE);
    assign ram_wren  = 1'b0;
    assign ram_rden  = (state == CNT_RD) || issue;
    assign ram_addr  = (state == CNT_RD) ? '0 : (issue ? issue_ptr : addr_hold);

    assign out_valid = (occupancy != '0);
    assign out_pos   = fifo_pos[rd_ptr[PTR_W-1:0]];
    assign out_pid   = fifo_pid[rd_ptr[PTR_W-1:0]];
    assign out_last  = fifo_last[rd_ptr[PTR_W-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= IDLE;
            wait_phase     <= 1'b0;
            issue_ptr      <= '0;
            particle_count <= '0;
            count_err      <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state          <= CNT_RD;
                        count_err      <= 1'b0;
                        particle_count <= '0;
                    end
                end
                CNT_RD: begin
                    state      <= CNT_WAIT;
                    wait_phase <= 1'b0;
                end
                CNT_WAIT: begin
                    if (!wait_phase) begin
                        wait_phase <= 1'b1;
                    end else begin
                        wait_phase <= 1'b0;
                        if (raw_count > MAX_COUNT) begin
                            count_err      <= 1'b1;
                            particle_count <= MAX_COUNT;
                        end else begin
                            particle_count <= raw_count;
                        end
                        if (raw_count == '0) begin
                            done  <= 1'b1;
                            state <= IDLE;
                        end else begin
                            state     <= STREAM;
                            issue_ptr <= ADDR_WIDTH'(1);
                        end
                    end
                end
                STREAM: begin
                    if (issue) begin
                        issue_ptr <= issue_ptr + 1'b1;
                        if (issue_ptr == particle_count) state <= DRAIN;
                    end
                end
                DRAIN: begin
                    // The last-flagged word is the final one written, so its handshake ends the sweep.
                    if (fire && out_last) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            addr_hold <= '0;
        end else if (ram_rden) begin
            addr_hold <= ram_addr;
        end
    end

    // Two-stage shadow of the RAM read latency; clearing it on reset discards stale returns.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pipe_v1   <= 1'b0;
            pipe_v2   <= 1'b0;
            pipe_pid1 <= '0;
            pipe_pid2 <= '0;
        end else begin
            pipe_v1   <= issue;
            pipe_pid1 <= issue_ptr;
            pipe_v2   <= pipe_v1;
            pipe_pid2 <= pipe_pid1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                fifo_pos[i]  <= '0;
                fifo_pid[i]  <= '0;
                fifo_last[i] <= 1'b0;
            end
        end else begin
            if (pipe_v2) begin
                fifo_pos[wr_ptr[PTR_W-1:0]]  <= ram_q;
                fifo_pid[wr_ptr[PTR_W-1:0]]  <= pipe_pid2;
                fifo_last[wr_ptr[PTR_W-1:0]] <= (pipe_pid2 == particle_count);
                wr_ptr                       <= wr_ptr + 1'b1;
            end
            if (fire) rd_ptr <= rd_ptr + 1'b1;
        end
    end

`ifdef CELL_READER_STALL_CNT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
        end else if (state == IDLE && start) begin
            stall_cycles <= '0;
        end else if ((state == STREAM || state == DRAIN) && out_valid && !out_ready
                     && stall_cycles != 16'hFFFF) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

endmodule

// File: doc/cell_pos_reader.md
# cell_pos_reader

Streaming read controller placed directly upstream of each per-cell position RAM (single-port, 2-cycle read latency, address 0 = particle count, addresses 1..N = {posz, posy, posx}). On `start` it fetches the count word, then reads particles 1..N and delivers them as a valid/ready stream to the force-evaluation pipeline. A small internal FIFO with credit-based issue absorbs the non-stallable RAM latency.

## Interface
- `DATA_WIDTH`, 96, width of one position word {posz, posy, posx}
- `ADDR_WIDTH`, 8, RAM address width
- `PARTICLE_NUM`, 220, RAM depth; max legal count = PARTICLE_NUM-1
- `FIFO_DEPTH`, 4, output buffer entries (power of 2, ≥ 3)

- `clock` in 1 — sole clock, rising edge
- `reset_n` in 1 — asynchronous, active-low reset
- `start` in 1 — one-cycle pulse; begin a cell sweep
- `busy` out 1 — sweep in progress
- `done` out 1 — one-cycle pulse after last particle accepted downstream
- `ram_addr` out ADDR_WIDTH — RAM address
- `ram_rden` out 1 — RAM read enable
- `ram_wren` out 1 — constant 0
- `ram_q` in DATA_WIDTH — RAM read data
- `out_valid` out 1 — stream word valid
- `out_ready` in 1 — downstream accept
- `out_pos` out DATA_WIDTH — particle position
- `out_pid` out ADDR_WIDTH — particle index (1-based RAM address)
- `out_last` out 1 — marks final particle of the cell
- `particle_count` out ADDR_WIDTH — count latched from address 0
- `count_err` out 1 — sticky per sweep: count word exceeded PARTICLE_NUM-1

## Operation
- States: IDLE, CNT_RD, CNT_WAIT, STREAM, DRAIN.
- IDLE: `busy`=0. `start` → CNT_RD; clears `count_err`, `particle_count`.
- CNT_RD: `ram_addr`=0, `ram_rden`=1 for one cycle → CNT_WAIT.
- CNT_WAIT: 2 cycles; on the second, capture `ram_q[ADDR_WIDTH-1:0]` as count. If count > PARTICLE_NUM-1: set `count_err`, clamp to PARTICLE_NUM-1. Count 0 → pulse `done`, return to IDLE (no stream word). Else → STREAM with issue pointer = 1.
- STREAM: issue a read (`ram_rden`=1, `ram_addr`=pointer, pointer++) in any cycle where in_flight + fifo_occupancy < FIFO_DEPTH. After issuing address = count → DRAIN.
- RAM data returning (2 cycles after issue) is always written into the FIFO with its pid; credit rule guarantees no overflow. `out_last` stored = (pid == count).
- DRAIN: no issue; wait until in_flight = 0, FIFO empty, and final word accepted → pulse `done`, IDLE.
- `start` while `busy` is ignored. `ram_rden`=0 and `ram_addr` holds last value when not issuing.
- FIFO head drives `out_*`; `out_valid` = FIFO non-empty. Pop on `out_valid && out_ready`.

## Timing
- Reset values: `busy`=0, `done`=0, `ram_rden`=0, `ram_wren`=0, `ram_addr`=0, `out_valid`=0, `out_pos`=0, `out_pid`=0, `out_last`=0, `particle_count`=0, `count_err`=0; FIFO empty, in_flight=0.
- Reset asserted mid-sweep: everything returns to reset values immediately; outstanding RAM returns after deassertion are discarded (in_flight cleared).
- `start` at cycle t: count read issued at t+1, count captured at t+3, first particle read at t+4, first `out_valid` at t+6 (FIFO write at t+6 edge, visible t+7 if registered — implementation must make it visible at t+7 max).
- Sustained throughput 1 particle/cycle with `out_ready`=1 constantly; FIFO_DEPTH ≥ 3 required for this.
- `out_*` stable while `out_valid`=1 and `out_ready`=0.
- `done` asserted cycle after final handshake; `busy` falls same cycle as `done`.

## Configuration
- `CELL_READER_STALL_CNT_EN` defined: adds output `stall_cycles` (16 bit), cleared on `start`, incremented (saturating at 0xFFFF) each cycle in STREAM/DRAIN with `out_valid`=1 and `out_ready`=0; held after `done`.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Count 5, `out_ready`=1: 5 words, pids 1..5, `out_last` only on pid 5, `done` once, first `out_valid` ≤ t+7.
- Count 0: no `out_valid`, `done` pulse at t+4, `particle_count`=0.
- Count word 250 (PARTICLE_NUM=220): `count_err`=1, 219 words streamed, last pid 219.
- Count 20, `out_ready` toggled pseudo-randomly (50%): all 20 words in order, no loss/duplication, FIFO never overflows, stall counter (macro on) equals stall cycles counted by bench.
- `reset_n` pulsed low after 3 words delivered: outputs at reset values immediately; subsequent `start` on count 4 streams pids 1..4 cleanly.
- `start` pulsed again mid-sweep: ignored, sweep completes with original count.
